// File: rtl/tm_step_engine.sv
// tm_step_engine: sequential Turing-machine step engine with a programmable
// transition table and an internal tape register array. A start pulse runs
// READ/EXEC transition pairs until halt entry, tape boundary or step limit.
// Optional build macro: TM_TAPE_WRAP_EN (circular tape, err_bound tied 0).
module tm_step_engine #(
  parameter int NUM_STATES = 8,
  parameter int SYM_W      = 3,
  parameter int TAPE_LEN   = 16,
  parameter int MAX_STEPS  = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [$clog2(TAPE_LEN)-1:0]         start_head,
  input  logic                                prog_we,
  input  logic [$clog2(NUM_STATES)+SYM_W-1:0] prog_addr,
  input  logic [$clog2(NUM_STATES)+SYM_W+1:0] prog_data,
  input  logic                                tape_we,
  input  logic [$clog2(TAPE_LEN)-1:0]         tape_addr,
  input  logic [SYM_W-1:0]                    tape_wdata,
  output logic [SYM_W-1:0]                    tape_rdata,
  output logic                                busy,
  output logic                                done,
  output logic                                halted,
  output logic                                err_bound,
  output logic                                timeout,
  output logic [$clog2(TAPE_LEN)-1:0]         head_pos,
  output logic [NUM_STATES-1:0]               state_onehot,
  output logic [$clog2(MAX_STEPS+1)-1:0]      step_count
);

  localparam int ST_W  = $clog2(NUM_STATES);
  localparam int H_W   = $clog2(TAPE_LEN);
  localparam int SC_W  = $clog2(MAX_STEPS+1);
  localparam int AD_W  = ST_W + SYM_W;
  localparam int EN_W  = AD_W + 2;
  localparam int TBL_N = NUM_STATES * (2**SYM_W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [H_W-1:0]   head_q, head_d;
  logic [ST_W-1:0]  st_q, st_d;
  logic [SC_W-1:0]  steps_q, steps_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic [SYM_W-1:0] tape_q [TAPE_LEN];
  logic [SYM_W-1:0] tape_d [TAPE_LEN];
  logic [EN_W-1:0]  tbl_q [TBL_N];
  logic [EN_W-1:0]  tbl_d [TBL_N];

  // Fields of the entry addressed by the current state and latched symbol.
  logic [EN_W-1:0]  ent;
  logic             ent_halt, ent_dir;
  logic [SYM_W-1:0] ent_wr;
  logic [ST_W-1:0]  ent_ns;
  logic [SC_W-1:0]  steps_inc;
  logic             at_left, at_right, blocked, ns_bad, prog_ok, host_ok;
  logic [H_W-1:0]   head_mv;

  assign ent       = tbl_q[{st_q, sym_q}];
  assign ent_halt  = ent[EN_W-1];
  assign ent_dir   = ent[EN_W-2];
  assign ent_wr    = ent[AD_W-1:ST_W];
  assign ent_ns    = ent[ST_W-1:0];
  assign steps_inc = steps_q + SC_W'(1);
  assign at_left   = (head_q == '0);
  assign at_right  = (head_q == H_W'(TAPE_LEN-1));
  assign host_ok   = (fsm_q == S_IDLE) || (fsm_q == S_DONE);

  // Out-of-range state indices only exist when NUM_STATES is not a power of 2.
  if (NUM_STATES == (1 << ST_W)) begin : g_ns_full
    assign ns_bad  = 1'b0;
    assign prog_ok = 1'b1;
  end else begin : g_ns_part
    assign ns_bad  = (ent_ns >= ST_W'(NUM_STATES));
    assign prog_ok = (prog_addr[AD_W-1:SYM_W] < ST_W'(NUM_STATES));
  end

`ifdef TM_TAPE_WRAP_EN
  assign blocked = 1'b0;
  assign head_mv = ent_dir ? (at_right ? '0 : head_q + H_W'(1))
                           : (at_left ? H_W'(TAPE_LEN-1) : head_q - H_W'(1));
`else
  assign blocked = ent_dir ? at_right : at_left;
  assign head_mv = ent_dir ? head_q + H_W'(1) : head_q - H_W'(1);
`endif

  // Next-state logic: host access while idle/done, then the READ/EXEC sequence.
  always_comb begin
    fsm_d    = fsm_q;
    head_d   = head_q;
    st_d     = st_q;
    steps_d  = steps_q;
    sym_d    = sym_q;
    halted_d = halted_q;
    err_d    = err_q;
    to_d     = to_q;
    tape_d   = tape_q;
    tbl_d    = tbl_q;
    if (host_ok) begin
      if (tape_we) tape_d[tape_addr] = tape_wdata;
      if (prog_we && prog_ok) tbl_d[prog_addr] = prog_data;
      if (start) begin
        head_d   = start_head;
        st_d     = '0;
        steps_d  = '0;
        halted_d = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        fsm_d    = S_READ;
      end
    end
    case (fsm_q)
      S_READ: begin
        sym_d = tape_q[head_q];
        fsm_d = S_EXEC;
      end
      S_EXEC: begin
        tape_d[head_q] = ent_wr;
        steps_d        = steps_inc;
        if (ent_halt || ns_bad) begin
          if (!ns_bad) st_d = ent_ns;
          halted_d = 1'b1;
          fsm_d    = S_DONE;
        end else if (blocked) begin
          st_d  = ent_ns;
          err_d = 1'b1;
          fsm_d = S_DONE;
        end else begin
          st_d   = ent_ns;
          head_d = head_mv;
          if (steps_inc == SC_W'(MAX_STEPS)) begin
            to_d  = 1'b1;
            fsm_d = S_DONE;
          end else begin
            fsm_d = S_READ;
          end
        end
      end
      default: ;
    endcase
  end

  // State, status, tape and table registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      head_q   <= '0;
      st_q     <= '0;
      steps_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      for (int i = 0; i < TAPE_LEN; i++) tape_q[i] <= '0;
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= '0;
    end else begin
      fsm_q    <= fsm_d;
      head_q   <= head_d;
      st_q     <= st_d;
      steps_q  <= steps_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      to_q     <= to_d;
      tape_q   <= tape_d;
      tbl_q    <= tbl_d;
    end
  end

  // Symbol latch; only consumed in EXEC right after READ loads it.
  always_ff @(posedge clk) begin
    sym_q <= sym_d;
  end

  assign tape_rdata   = tape_q[tape_addr];
  assign busy         = (fsm_q == S_READ) || (fsm_q == S_EXEC);
  assign done         = (fsm_q == S_DONE);
  assign halted       = halted_q;
  assign err_bound    = err_q;
  assign timeout      = to_q;
  assign head_pos     = head_q;
  assign state_onehot = NUM_STATES'(1) << st_q;
  assign step_count   = steps_q;

endmodule

// File: tb/tb_tm_step_engine.sv
// Self-checking bench for tm_step_engine: behavioural machine model plus
// directed scenarios and randomized programs/tapes/disturbances.
module tb_tm_step_engine;
  localparam int NS   = 8;
  localparam int SW   = 3;
  localparam int TL   = 16;
  localparam int MS   = 20;
  localparam int STW  = $clog2(NS);
  localparam int HW   = $clog2(TL);
  localparam int SCW  = $clog2(MS+1);
  localparam int ADW  = STW + SW;
  localparam int ENW  = ADW + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0;
  logic [HW-1:0] start_head = '0;
  logic prog_we = 1'b0;
  logic [ADW-1:0] prog_addr = '0;
  logic [ENW-1:0] prog_data = '0;
  logic tape_we = 1'b0;
  logic [HW-1:0] tape_addr = '0;
  logic [SW-1:0] tape_wdata = '0;
  logic [SW-1:0] tape_rdata;
  logic busy, done, halted, err_bound, timeout;
  logic [HW-1:0] head_pos;
  logic [NS-1:0] state_onehot;
  logic [SCW-1:0] step_count;

  tm_step_engine #(.NUM_STATES(NS), .SYM_W(SW), .TAPE_LEN(TL), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_head(start_head),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
    .tape_rdata(tape_rdata), .busy(busy), .done(done), .halted(halted),
    .err_bound(err_bound), .timeout(timeout), .head_pos(head_pos),
    .state_onehot(state_onehot), .step_count(step_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SW-1:0]  m_tape [TL];
  logic [ENW-1:0] m_tbl [NS*(1<<SW)];
  int m_head, m_st, m_steps, run_t;
  bit m_run, m_done, m_hal, m_err, m_to;

  task automatic model_clear();
    for (int i = 0; i < TL; i++) m_tape[i] = '0;
    for (int i = 0; i < NS*(1<<SW); i++) m_tbl[i] = '0;
    m_head = 0; m_st = 0; m_steps = 0; run_t = 0;
    m_run = 0; m_done = 0; m_hal = 0; m_err = 0; m_to = 0;
  endtask

  task automatic model_finish();
    m_run = 0;
    m_done = 1;
  endtask

  // One full machine transition from the current configuration.
  task automatic model_step();
    logic [ENW-1:0] e;
    int ns, nh;
    e = m_tbl[m_st*(1<<SW) + int'(m_tape[m_head])];
    ns = int'(e[STW-1:0]);
    m_tape[m_head] = e[ADW-1:STW];
    m_steps++;
    if (e[ENW-1] || ns >= NS) begin
      if (ns < NS) m_st = ns;
      m_hal = 1;
      model_finish();
      return;
    end
    m_st = ns;
    nh = e[ENW-2] ? m_head + 1 : m_head - 1;
    if (nh < 0 || nh >= TL) begin
`ifdef TM_TAPE_WRAP_EN
      nh = (nh + TL) % TL;
`else
      m_err = 1;
      model_finish();
      return;
`endif
    end
    m_head = nh;
    if (m_steps == MS) begin
      m_to = 1;
      model_finish();
    end
  endtask

  // A transition completes every second clock after the accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else if (m_run) begin
      run_t++;
      if (run_t % 2 == 0) model_step();
    end else begin
      if (tape_we) m_tape[tape_addr] = tape_wdata;
      if (prog_we) m_tbl[prog_addr] = prog_data;
      if (start) begin
        m_head = int'(start_head); m_st = 0; m_steps = 0;
        m_done = 0; m_hal = 0; m_err = 0; m_to = 0;
        m_run = 1; run_t = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("halted", halted, m_hal);
      chk("err_bound", err_bound, m_err);
      chk("timeout", timeout, m_to);
      chk("head_pos", head_pos, m_head);
      chk("state_onehot", state_onehot, 32'(1) << m_st);
      chk("step_count", step_count, m_steps);
      chk("tape_rdata", tape_rdata, m_tape[tape_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic prog(input int a, input int d);
    prog_we = 1'b1; prog_addr = ADW'(a); prog_data = ENW'(d);
    tick();
    prog_we = 1'b0;
  endtask

  task automatic tput(input int a, input int d);
    tape_we = 1'b1; tape_addr = HW'(a); tape_wdata = SW'(d);
    tick();
    tape_we = 1'b0;
  endtask

  task automatic start_run(input int h);
    start = 1'b1; start_head = HW'(h);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 2*MS + 10) begin
      tick();
      c++;
    end
    chk("wait_done", done, 1);
  endtask

  task automatic tape_is(input string nm, input int a, input int exp);
    tape_addr = HW'(a);
    #1;
    chk(nm, tape_rdata, exp);
  endtask

  task automatic walk_setup();
    prog(0, 8'h48);
    prog(1, 8'h88);
    tput(3, 1);
  endtask

  task automatic walk_result(input string tag, input int c);
    chk({tag, "_lat"}, c, 9);
    chk({tag, "_head"}, head_pos, 3);
    chk({tag, "_steps"}, step_count, 4);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_err"}, err_bound, 0);
    for (int i = 0; i < 4; i++) tape_is({tag, "_tape"}, i, 1);
  endtask

  initial begin
    int c;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_onehot", state_onehot, 1);
    chk("rst_steps", step_count, 0);

    // Walk-right halt
    do_reset();
    walk_setup();
    start_run(0);
    wait_done(1, c);
    walk_result("walk", c);

    // Start and host writes while busy are ignored
    do_reset();
    walk_setup();
    start_run(0);
    tick(); tick();
    start = 1'b1; start_head = HW'(7);
    prog_we = 1'b1; prog_addr = '0; prog_data = 8'h11;
    tape_we = 1'b1; tape_addr = HW'(5); tape_wdata = SW'(7);
    tick();
    start = 1'b0; prog_we = 1'b0; tape_we = 1'b0;
    wait_done(4, c);
    walk_result("busy", c);
    tape_is("busy_tape5", 5, 0);
    for (int i = 0; i < 3; i++) tput(i, 0);
    start_run(0);
    wait_done(1, c);
    walk_result("busy_rerun", c);

`ifndef TM_TAPE_WRAP_EN
    // Left boundary
    do_reset();
    prog(0, 8'h11);
    start_run(0);
    wait_done(1, c);
    chk("lb_lat", c, 3);
    chk("lb_err", err_bound, 1);
    chk("lb_halted", halted, 0);
    chk("lb_head", head_pos, 0);
    chk("lb_onehot", state_onehot, 2);
    chk("lb_steps", step_count, 1);
    tape_is("lb_tape0", 0, 2);
`else
    // Circular tape
    do_reset();
    prog(0, 8'h11);
    prog(8, 8'h99);
    start_run(0);
    wait_done(1, c);
    chk("wrap_lat", c, 5);
    chk("wrap_head", head_pos, 15);
    chk("wrap_halted", halted, 1);
    chk("wrap_err", err_bound, 0);
    tape_is("wrap_tape15", 15, 3);
`endif

    // Step limit
    do_reset();
    prog(0, 8'h41);
    prog(8, 8'h00);
    start_run(5);
    wait_done(1, c);
    chk("to_lat", c, 41);
    chk("to_flag", timeout, 1);
    chk("to_steps", step_count, 20);
    chk("to_head", head_pos, 5);

    // Reset mid-run
    do_reset();
    walk_setup();
    start_run(0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_onehot", state_onehot, 1);
    for (int i = 0; i < TL; i++) tape_is("mr_tape", i, 0);
    rst_n = 1'b1;
    tick();

    // Randomized programs, tapes and disturbances
    for (int r = 0; r < 60; r++) begin
      if (r % 8 == 0) do_reset();
      for (int k = 0; k < int'($urandom_range(0, 12)); k++)
        prog(int'($urandom_range(0, NS*(1<<SW)-1)),
             (($urandom_range(0, 5) == 0) ? 128 : 0) + int'($urandom_range(0, 127)));
      for (int k = 0; k < int'($urandom_range(0, 6)); k++)
        tput(int'($urandom_range(0, TL-1)), int'($urandom_range(0, (1<<SW)-1)));
      tape_we = ($urandom_range(0, 1) == 1);
      tape_addr = HW'($urandom_range(0, TL-1));
      tape_wdata = SW'($urandom_range(0, (1<<SW)-1));
      start_run(int'($urandom_range(0, TL-1)));
      tape_we = 1'b0;
      c = 1;
      while (!done && c < 2*MS + 10) begin
        start = ($urandom_range(0, 7) == 0);
        start_head = HW'($urandom_range(0, TL-1));
        prog_we = ($urandom_range(0, 5) == 0);
        prog_addr = ADW'($urandom_range(0, NS*(1<<SW)-1));
        prog_data = ENW'($urandom_range(0, (1<<ENW)-1));
        tape_we = ($urandom_range(0, 5) == 0);
        tape_addr = HW'($urandom_range(0, TL-1));
        tape_wdata = SW'($urandom_range(0, (1<<SW)-1));
        tick();
        c++;
      end
      start = 1'b0; prog_we = 1'b0; tape_we = 1'b0;
      chk("rnd_done", done, 1);
      chk("rnd_lat", c, 2*m_steps + 1);
      chk("rnd_one_flag", 32'(halted) + 32'(err_bound) + 32'(timeout), 1);
      tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tm_step_engine.md
Name: tm_step_engine

Overview:
Sequential, parametrised successor to the combinational Turing-machine transition logic (direction/next-state/write decode).
- Holds a programmable transition table and an internal tape register array.
- Executes transitions autonomously from a start pulse until one of: halt entry, tape boundary error, or step limit.
- Sits between the host/IO shim (programming, tape load/readback) and the display of head position and one-hot state.

Parameters:
NUM_STATES, 8, number of machine states; must be ≥2; state 0 is start state "A"
SYM_W, 3, symbol width in bits; table has NUM_STATES*2^SYM_W entries
TAPE_LEN, 16, tape cells, indices 0..TAPE_LEN-1
MAX_STEPS, 255, transition limit before timeout; ≥1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins run
start_head  in  $clog2(TAPE_LEN)  initial head position, sampled with start
prog_we  in  1  transition-table write strobe
prog_addr  in  $clog2(NUM_STATES)+SYM_W  entry index = {state_idx, symbol}
prog_data  in  $clog2(NUM_STATES)+SYM_W+2  {halt, dir, wr_sym, next_state_idx}; dir 1=right, 0=left
tape_we  in  1  tape write strobe
tape_addr  in  $clog2(TAPE_LEN)  tape write/read index
tape_wdata  in  SYM_W  tape write data
tape_rdata  out  SYM_W  combinational tape[tape_addr]
busy  out  1  run in progress
done  out  1  run finished; level, held until next start
halted  out  1  finished on halt entry
err_bound  out  1  finished on left move at 0 / right move at TAPE_LEN-1
timeout  out  1  finished on step limit
head_pos  out  $clog2(TAPE_LEN)  current head index
state_onehot  out  NUM_STATES  current state, one-hot
step_count  out  $clog2(MAX_STEPS+1)  transitions executed

Behaviour:
- Reset (async):
  - FSM=IDLE; all status outputs 0; head_pos=0; state_onehot=1 (A); step_count=0.
  - Tape cells and table entries all cleared to 0.
  - Reset mid-run aborts the run immediately; no partial write survives.
- FSM IDLE -> READ -> EXEC -> (READ | DONE); DONE -> READ on start.
- start accepted in IDLE or DONE only:
  - head_pos<=start_head; state<=0; step_count<=0; done/halted/err_bound/timeout<=0; go READ.
  - start while busy is ignored.
- READ (busy=1): latch sym=tape[head_pos].
- EXEC (busy=1):
  - Fetch entry {state,sym}; write tape[head_pos]<=wr_sym; state<=next_state_idx; step_count+1.
  - Then evaluate, first match wins:
    - halt=1: no move; DONE with halted=1.
    - Move would leave tape: no move; DONE with err_bound=1.
    - Otherwise move head ±1; if new step_count==MAX_STEPS, DONE with timeout=1, else READ.
- Exactly one status flag is set in DONE; done=1, busy=0 in DONE.
- Latency: run of N transitions → done rises 2N+1 cycles after the start cycle.
- prog_we/tape_we:
  - Honoured in IDLE/DONE; ignored while busy.
  - Same-cycle tape_we with start: write lands before READ.
  - prog_addr state field ≥NUM_STATES: write ignored.
- next_state_idx ≥NUM_STATES in a fetched entry: treated as halt; state unchanged.
- tape_rdata always valid combinationally, including during a run.

Optional Feature:
TM_TAPE_WRAP_EN:
- Defined: the tape is circular. Left move at 0 → TAPE_LEN-1; right move at TAPE_LEN-1 → 0. err_bound is tied 0.
- Undefined: boundary behaviour is as specified in Behaviour.

Test Plan:
- Walk-right halt:
  - Stimulus: entry{0,0}={0,1,1,0}, entry{0,1}={1,x,1,0}; tape[3]=1, rest 0; start_head=0.
  - Response: tape[0..2]=1, head_pos=3, step_count=4, halted=1, done 9 cycles after start.
- Left boundary:
  - Stimulus: entry{0,0}={0,0,2,1}; start_head=0.
  - Response: err_bound=1, tape[0]=2, head_pos=0, state_onehot=0x02, step_count=1.
- Timeout:
  - Stimulus: MAX_STEPS=20; entry{0,0}={0,1,0,1}, entry{1,0}={0,0,0,0}; start_head=5.
  - Response: timeout=1, step_count=20, head_pos=5, done at cycle 41.
- Start/programming while busy:
  - Stimulus: second start plus prog_we/tape_we at cycle 3 of the walk-right run.
  - Response: results identical to the walk-right case; table and tape unchanged by the ignored writes.
- Reset mid-run:
  - Stimulus: rst_n low at cycle 4 of walk-right.
  - Response: busy=0, done=0, state_onehot=0x01, tape_rdata=0 at all addresses.
- Wrap (with TM_TAPE_WRAP_EN):
  - Stimulus: left-boundary program, plus entry{1,0}={1,x,3,1}.
  - Response: head_pos=15, tape[15]=3, halted=1, err_bound=0.
